// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - forwarding/stall controller with internal in-flight tag tracking
//
// Purpose: tracks destination tags of instructions issued past ID in a FWD_STAGES-deep
// shift register. For the instruction in ID, it picks the youngest matching producer
// for each source operand, and it stalls when that producer is a load whose result is
// not usable yet.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   id_valid                 valid instruction in ID
//   id_rs/id_rt              source registers; id_use_rs/id_use_rt qualify them
//   id_rd/id_reg_write       destination register and its write enable
//   id_is_load               ID instruction is a load
//   ex_flush                 squash the ID instruction (taken branch/jump)
//   stall                    hold PC and IF/ID, bubble into stage 1
//   fwa/fwb                  operand select: 0 = regfile, k = stage k
//   stall_cnt                stall cycle counter (HAZ_PERF_CNT_EN), else tied to 0
//
// Optional feature macro: HAZ_PERF_CNT_EN (saturating stall counter).

module hazard_scoreboard_unit #(
  parameter int REG_AW     = 4,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16,
  parameter int FW_W       = $clog2(FWD_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_flush,
  output logic              stall,
  output logic [FW_W-1:0]   fwa,
  output logic [FW_W-1:0]   fwb,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Index i holds stage k = i+1 (index 0 is EX, top index retires).
  logic [FWD_STAGES-1:0] v_q, v_d;
  logic [FWD_STAGES-1:0] ld_q, ld_d;
  logic [REG_AW-1:0]     rd_q [FWD_STAGES];
  logic [REG_AW-1:0]     rd_d [FWD_STAGES];

  logic            haz_a, haz_b;
  logic [FW_W-1:0] fwa_c, fwb_c;
  logic            stall_c;

  // Youngest-producer select: scan oldest to youngest so the smallest k wins.
  always_comb begin
    fwa_c = '0;
    fwb_c = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (id_valid && id_use_rs && v_q[i] && (rd_q[i] == id_rs)) begin
        fwa_c = FW_W'(i + 1);
        haz_a = ld_q[i] && ((i + 1) <= LOAD_LAT);
      end
      if (id_valid && id_use_rt && v_q[i] && (rd_q[i] == id_rt)) begin
        fwb_c = FW_W'(i + 1);
        haz_b = ld_q[i] && ((i + 1) <= LOAD_LAT);
      end
    end
    stall_c = id_valid && !ex_flush && (haz_a || haz_b);
  end

  assign stall = stall_c;
  assign fwa   = fwa_c;
  assign fwb   = fwb_c;

  // Older stages always shift, even while stalling or flushing, so a load hazard
  // clears on its own once the load moves past LOAD_LAT.
  always_comb begin
    v_d[0]  = id_valid && id_reg_write && !stall_c && !ex_flush;
    ld_d[0] = id_is_load;
    rd_d[0] = id_rd;
    for (int i = 1; i < FWD_STAGES; i++) begin
      v_d[i]  = v_q[i-1];
      ld_d[i] = ld_q[i-1];
      rd_d[i] = rd_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int i = 0; i < FWD_STAGES; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      v_q  <= v_d;
      ld_q <= ld_d;
      for (int i = 0; i < FWD_STAGES; i++) begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
